// File: rtl/pe_array_sequencer_pkg.sv
// Shared constants, state codes and sizing helpers for the PE array sequencer.
package pe_array_sequencer_pkg;

    localparam int unsigned DEF_N_VISIBLE = 784;
    localparam int unsigned DEF_N_HIDDEN  = 500;
    localparam int unsigned DEF_PE_NUM    = 64;
    localparam int unsigned DEF_BW_K      = 4;

    // PE state_signal codes; idle and write-back must differ from both accumulate codes
    localparam logic [2:0] SEQ_IDLE = 3'd0;
    localparam logic [2:0] GEN_VH   = 3'd1;
    localparam logic [2:0] REC_HV   = 3'd2;
    localparam logic [2:0] SEQ_WB   = 3'd3;

    typedef enum logic {
        PH_GEN = 1'b0,
        PH_REC = 1'b1
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WB    = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Counter width able to index 0..n-1, never narrower than one bit
    function automatic int unsigned bits_for(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pe_array_sequencer_counter.sv
// Row/tile counter pair with terminal-count flags for the sequencer.
module seq_addr_counter #(
    parameter int unsigned BW_ROW  = 2,
    parameter int unsigned BW_TILE = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BW_ROW-1:0]  row_max,
    input  logic [BW_TILE-1:0] tile_max,
    input  logic               row_clr,
    input  logic               row_inc,
    input  logic               tile_clr,
    input  logic               tile_inc,
    output logic [BW_ROW-1:0]  row,
    output logic [BW_TILE-1:0] tile,
    output logic               row_last_c,
    output logic               tile_last_c
);

    assign row_last_c  = (row == row_max);
    assign tile_last_c = (tile == tile_max);

    // Row index; holds at its terminal value instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
        end else if (row_clr) begin
            row <= '0;
        end else if (row_inc && !row_last_c) begin
            row <= row + BW_ROW'(1);
        end
    end

    // Tile index; holds at its terminal value instead of wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile <= '0;
        end else if (tile_clr) begin
            tile <= '0;
        end else if (tile_inc && !tile_last_c) begin
            tile <= tile + BW_TILE'(1);
        end
    end

endmodule

// File: rtl/pe_array_sequencer.sv
// Gibbs GEN/REC sequencer: tiles outputs over the PE array, streams source rows, strobes write-back.
module pe_array_sequencer
    import pe_array_sequencer_pkg::*;
#(
    parameter int unsigned N_VISIBLE = DEF_N_VISIBLE,
    parameter int unsigned N_HIDDEN  = DEF_N_HIDDEN,
    parameter int unsigned PE_NUM    = DEF_PE_NUM,
    parameter int unsigned BW_K      = DEF_BW_K,
    localparam int unsigned TILES_H  = ceil_div(N_HIDDEN, PE_NUM),
    localparam int unsigned TILES_V  = ceil_div(N_VISIBLE, PE_NUM),
    localparam int unsigned BW_ROW   = bits_for(max_u(N_VISIBLE, N_HIDDEN)),
    localparam int unsigned BW_TILE  = bits_for(max_u(TILES_H, TILES_V))
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [BW_K-1:0]    k_steps,
    output logic               busy,
    output logic               done,
    output logic [2:0]         state_signal,
    output logic               pe_en,
    output logic [BW_ROW-1:0]  src_addr,
    output logic               src_sel,
    input  logic               src_bit,
    output logic [BW_ROW-1:0]  w_row,
    output logic [BW_TILE-1:0] w_tile,
    output logic               wb_we,
    output logic [BW_TILE-1:0] wb_tile,
    output logic               wb_last
);

    seq_state_t         state_q, state_d;
    phase_t             phase_q, phase_d;
    logic [BW_K-1:0]    kcnt_q, kcnt_d;
    logic               acc_q;

    logic [BW_ROW-1:0]  row, row_max;
    logic [BW_TILE-1:0] tile, tile_max;
    logic               row_last_c, tile_last_c;
    logic               row_clr, row_inc, tile_clr, tile_inc;

    logic               busy_d, done_d, wb_we_d, wb_last_d;
    logic [2:0]         state_signal_d;

    // Source rows and output tiles both depend on the current phase
    assign row_max  = (phase_q == PH_REC) ? BW_ROW'(N_HIDDEN - 1)  : BW_ROW'(N_VISIBLE - 1);
    assign tile_max = (phase_q == PH_REC) ? BW_TILE'(TILES_V - 1)  : BW_TILE'(TILES_H - 1);

    seq_addr_counter #(
        .BW_ROW  (BW_ROW),
        .BW_TILE (BW_TILE)
    ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .row_max     (row_max),
        .tile_max    (tile_max),
        .row_clr     (row_clr),
        .row_inc     (row_inc),
        .tile_clr    (tile_clr),
        .tile_inc    (tile_inc),
        .row         (row),
        .tile        (tile),
        .row_last_c  (row_last_c),
        .tile_last_c (tile_last_c)
    );

    assign src_addr = row;
    assign w_row    = row;
    assign w_tile   = tile;
    assign wb_tile  = tile;
    assign src_sel  = 1'(phase_q);

    // Source bit and weights arrive one cycle after the row is issued; gate en with the delayed flag
    assign pe_en = acc_q & src_bit;

    // Next-state, counter control and next registered outputs
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        kcnt_d   = kcnt_q;
        row_clr  = 1'b0;
        row_inc  = 1'b0;
        tile_clr = 1'b0;
        tile_inc = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    kcnt_d   = k_steps;
                    phase_d  = PH_GEN;
                    row_clr  = 1'b1;
                    tile_clr = 1'b1;
                    state_d  = (k_steps != '0) ? ST_ACC : ST_DONE;
                end
            end
            ST_ACC: begin
                if (row_last_c) begin
                    state_d = ST_DRAIN;
                end else begin
                    row_inc = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_WB;
            end
            ST_WB: begin
                row_clr = 1'b1;
                state_d = ST_ACC;
                if (!tile_last_c) begin
                    tile_inc = 1'b1;
                end else begin
                    tile_clr = 1'b1;
                    if (phase_q == PH_GEN) begin
                        phase_d = PH_REC;
                    end else begin
                        kcnt_d = kcnt_q - BW_K'(1);
                        if (kcnt_q == BW_K'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            phase_d = PH_GEN;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d    = (state_d != ST_IDLE);
        done_d    = (state_d == ST_DONE);
        wb_we_d   = (state_d == ST_WB);
        wb_last_d = (state_d == ST_WB) && tile_last_c;

        case (state_d)
            ST_ACC, ST_DRAIN: state_signal_d = (phase_d == PH_REC) ? REC_HV : GEN_VH;
            ST_WB:            state_signal_d = SEQ_WB;
            default:          state_signal_d = SEQ_IDLE;
        endcase
    end

    // State, phase, step count, alignment flag and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            phase_q      <= PH_GEN;
            kcnt_q       <= '0;
            acc_q        <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            wb_we        <= 1'b0;
            wb_last      <= 1'b0;
            state_signal <= SEQ_IDLE;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            kcnt_q       <= kcnt_d;
            acc_q        <= (state_q == ST_ACC);
            busy         <= busy_d;
            done         <= done_d;
            wb_we        <= wb_we_d;
            wb_last      <= wb_last_d;
            state_signal <= state_signal_d;
        end
    end

endmodule

// File: tb/tb_pe_array_sequencer.sv
// Directed bench for pe_array_sequencer with 1-cycle source/weight RAMs and a PE accumulator model.
module tb_pe_array_sequencer;
    import pe_array_sequencer_pkg::*;

    localparam int unsigned NV = 4;
    localparam int unsigned NH = 3;
    localparam int unsigned PE = 2;
    localparam int unsigned BK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BK-1:0] k_steps;
    logic          busy;
    logic          done;
    logic [2:0]    state_signal;
    logic          pe_en;
    logic [1:0]    src_addr;
    logic          src_sel;
    logic          src_bit;
    logic [1:0]    w_row;
    logic [0:0]    w_tile;
    logic          wb_we;
    logic [0:0]    wb_tile;
    logic          wb_last;

    int n_checks = 0;
    int n_fail   = 0;

    logic vis[4];
    logic hid[4];
    int   w_mem[4][4];
    int   wq[2];
    int   psum[2];

    // Expected per-cycle behaviour of one k=1 run, index 0 = first ACC cycle
    int ss_tab[22]   = '{1,1,1,1,1,3, 1,1,1,1,1,3, 2,2,2,2,3, 2,2,2,2,3};
    int addr_tab[22] = '{0,1,2,3,3,0, 0,1,2,3,3,0, 0,1,2,2,0, 0,1,2,2,0};
    int pe_tab[22]   = '{0,1,0,1,0,0, 0,1,0,1,0,0, 0,0,1,0,0, 0,0,1,0,0};
    int sel_tab[22]  = '{0,0,0,0,0,0, 0,0,0,0,0,0, 1,1,1,1,1, 1,1,1,1,1};
    int tile_tab[22] = '{0,0,0,0,0,0, 1,1,1,1,1,1, 0,0,0,0,0, 1,1,1,1,1};
    int wb_last_tab[4] = '{0,1,0,1};
    int ps0_tab[4]     = '{40,44,20,22};
    int ps1_tab[4]     = '{42,46,21,23};

    always #5 clk = ~clk;

    pe_array_sequencer #(
        .N_VISIBLE (NV),
        .N_HIDDEN  (NH),
        .PE_NUM    (PE),
        .BW_K      (BK)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .k_steps      (k_steps),
        .busy         (busy),
        .done         (done),
        .state_signal (state_signal),
        .pe_en        (pe_en),
        .src_addr     (src_addr),
        .src_sel      (src_sel),
        .src_bit      (src_bit),
        .w_row        (w_row),
        .w_tile       (w_tile),
        .wb_we        (wb_we),
        .wb_tile      (wb_tile),
        .wb_last      (wb_last)
    );

    // Source-bit RAM, weight RAM (1-cycle latency) and PE accumulators
    always_ff @(posedge clk) begin
        src_bit <= src_sel ? hid[src_addr] : vis[src_addr];
        for (int j = 0; j < 2; j++) begin
            wq[j] <= w_mem[w_row][int'(w_tile) * 2 + j];
            if (state_signal == GEN_VH || state_signal == REC_HV) begin
                if (pe_en) psum[j] <= psum[j] + wq[j];
            end else begin
                psum[j] <= 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
        n_checks++;
        assert (obs === expd) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " busy"},    32'(busy),         32'd0);
        check({tag, " done"},    32'(done),         32'd0);
        check({tag, " pe_en"},   32'(pe_en),        32'd0);
        check({tag, " wb_we"},   32'(wb_we),        32'd0);
        check({tag, " wb_last"}, 32'(wb_last),      32'd0);
        check({tag, " ss"},      32'(state_signal), 32'(SEQ_IDLE));
        check({tag, " addr"},    32'(src_addr),     32'd0);
        check({tag, " w_tile"},  32'(w_tile),       32'd0);
        check({tag, " sel"},     32'(src_sel),      32'd0);
    endtask

    // One k=1 run checked cycle by cycle; optionally pokes start mid-run
    task automatic run_k1(input bit disturb);
        int wbn = 0;
        start   = 1'b1;
        k_steps = 4'd1;
        tick();
        start   = 1'b0;
        for (int c = 0; c < 22; c++) begin
            check($sformatf("k1 ss c%0d", c),    32'(state_signal), 32'(ss_tab[c]));
            check($sformatf("k1 busy c%0d", c),  32'(busy),         32'd1);
            check($sformatf("k1 done c%0d", c),  32'(done),         32'd0);
            check($sformatf("k1 pe_en c%0d", c), 32'(pe_en),        32'(pe_tab[c]));
            check($sformatf("k1 sel c%0d", c),   32'(src_sel),      32'(sel_tab[c]));
            if (ss_tab[c] == 3) begin
                check($sformatf("k1 wb_we c%0d", c),   32'(wb_we),   32'd1);
                check($sformatf("k1 wb_tile c%0d", c), 32'(wb_tile), 32'(tile_tab[c]));
                check($sformatf("k1 wb_last c%0d", c), 32'(wb_last), 32'(wb_last_tab[wbn]));
                check($sformatf("k1 psum0 c%0d", c),   32'(psum[0]), 32'(ps0_tab[wbn]));
                check($sformatf("k1 psum1 c%0d", c),   32'(psum[1]), 32'(ps1_tab[wbn]));
                wbn++;
            end else begin
                check($sformatf("k1 wb_we c%0d", c),  32'(wb_we),    32'd0);
                check($sformatf("k1 addr c%0d", c),   32'(src_addr), 32'(addr_tab[c]));
                check($sformatf("k1 w_row c%0d", c),  32'(w_row),    32'(addr_tab[c]));
                check($sformatf("k1 w_tile c%0d", c), 32'(w_tile),   32'(tile_tab[c]));
            end
            if (disturb && (c == 2 || c == 5 || c == 14)) begin
                start   = 1'b1;
                k_steps = 4'd3;
            end
            tick();
            start = 1'b0;
        end
        check("k1 done pulse", 32'(done),         32'd1);
        check("k1 done ss",    32'(state_signal), 32'(SEQ_IDLE));
        check("k1 done pe_en", 32'(pe_en),        32'd0);
        check("k1 done wb_we", 32'(wb_we),        32'd0);
        tick();
        check("k1 after done", 32'(done), 32'd0);
        check("k1 after busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int       nwb;
        int       ndone;
        int       done_at;
        logic [7:0] sel_seq;

        vis = '{1'b1, 1'b0, 1'b1, 1'b0};
        hid = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w_mem[r][c] = 10 * (r + 1) + c;

        rst     = 1'b0;
        start   = 1'b0;
        k_steps = '0;
        repeat (3) tick();
        check_idle_outputs("reset held");
        rst = 1'b1;
        tick();
        check_idle_outputs("reset released");

        // Plain k=1 run with pattern 1010 on visible, 010 on hidden
        run_k1(1'b0);
        tick();

        // Same run with stray start pulses during ACC and WB
        run_k1(1'b1);
        tick();

        // k=2: phase order via src_sel at each write-back, single done pulse
        start   = 1'b1;
        k_steps = 4'd2;
        tick();
        start   = 1'b0;
        nwb     = 0;
        ndone   = 0;
        done_at = -1;
        sel_seq = '0;
        for (int c = 0; c < 80; c++) begin
            if (wb_we) begin
                if (nwb < 8) sel_seq[nwb] = src_sel;
                nwb++;
            end
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = c;
            end
            tick();
        end
        check("k2 wb count",   32'(nwb),     32'd8);
        check("k2 phase seq",  32'(sel_seq), 32'h0000_00CC);
        check("k2 done count", 32'(ndone),   32'd1);
        check("k2 done cycle", 32'(done_at), 32'd44);
        check("k2 busy end",   32'(busy),    32'd0);

        // k=0: immediate done, no PE activity
        start   = 1'b1;
        k_steps = 4'd0;
        tick();
        start   = 1'b0;
        check("k0 done",  32'(done),         32'd1);
        check("k0 pe_en", 32'(pe_en),        32'd0);
        check("k0 wb_we", 32'(wb_we),        32'd0);
        check("k0 ss",    32'(state_signal), 32'(SEQ_IDLE));
        for (int c = 0; c < 3; c++) begin
            tick();
            check($sformatf("k0 done c%0d", c),  32'(done),  32'd0);
            check($sformatf("k0 busy c%0d", c),  32'(busy),  32'd0);
            check($sformatf("k0 pe_en c%0d", c), 32'(pe_en), 32'd0);
            check($sformatf("k0 wb_we c%0d", c), 32'(wb_we), 32'd0);
        end

        // Asynchronous reset in the middle of ACC while pe_en is high
        start   = 1'b1;
        k_steps = 4'd1;
        tick();
        start   = 1'b0;
        repeat (3) tick();
        check("mid pre ss",    32'(state_signal), 32'(GEN_VH));
        check("mid pre pe_en", 32'(pe_en),        32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_idle_outputs("mid reset");
        #3;
        rst = 1'b1;
        tick();
        check_idle_outputs("mid released");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
